// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: config register map,
// FSM state encodings and the CAUSE register layout.
package irq_ctrl_pkg;

    localparam int unsigned CFG_ADDR_W = 2;

    localparam logic [CFG_ADDR_W-1:0] CFG_MASK  = 2'd0;
    localparam logic [CFG_ADDR_W-1:0] CFG_PEND  = 2'd1;
    localparam logic [CFG_ADDR_W-1:0] CFG_CAUSE = 2'd2;
    localparam logic [CFG_ADDR_W-1:0] CFG_CNT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } state_t;

    typedef struct packed {
        logic        busy;
        state_t      state;
        logic [28:0] id;
    } cause_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Combinational source picker: first active source found when searching
// upward from rr_ptr_i with wrap; rr_ptr_i = 0 gives lowest-index-wins.
module irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_IRQ-1:0] active_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic               valid_c_o,
    output logic [ID_W-1:0]    sel_c_o
);

    int j;

    // Walk offsets from far to near so the nearest hit is the last one written.
    always_comb begin
        valid_c_o = 1'b0;
        sel_c_o   = '0;
        j         = 0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            j = int'(rr_ptr_i) + i;
            if (j >= int'(NUM_IRQ)) begin
                j = j - int'(NUM_IRQ);
            end
            if (active_i[j]) begin
                valid_c_o = 1'b1;
                sel_c_o   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller feeding CP0's single ir_in.
// Define IRQ_RR_EN for round-robin selection; default is fixed lowest-index priority.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IRQ-1:0]    irq_src,
    input  logic                  ir_en,
    input  logic                  ir_taken,
    input  logic                  eret,
    input  logic                  cfg_we,
    input  logic [CFG_ADDR_W-1:0] cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic [31:0]           cfg_rdata,
    output logic                  ir_out,
    output logic [ID_W-1:0]       irq_id,
    output logic                  busy
);

    logic [NUM_IRQ-1:0] src_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] rise, clr, active;
    logic [31:0]        taken_cnt_q;
    state_t             state_q;
    logic               ir_out_q;
    logic [ID_W-1:0]    irq_id_q;
    logic [ID_W-1:0]    rr_ptr;
    logic               sel_valid;
    logic [ID_W-1:0]    sel;
    logic               take_ok;
    cause_t             cause;
    logic               unused_wdata;

    assign rise         = irq_src & ~src_q;
    assign active       = pending_q & mask_q;
    assign take_ok      = (state_q == ST_REQ) && ir_taken;
    assign unused_wdata = ^(cfg_wdata >> NUM_IRQ);

    // A fresh rise always survives a same-cycle clear.
    always_comb begin
        clr = '0;
        if (take_ok) begin
            clr[irq_id_q] = 1'b1;
        end
        if (cfg_we && (cfg_addr == CFG_PEND)) begin
            clr = clr | cfg_wdata[NUM_IRQ-1:0];
        end
        pending_d = (pending_q & ~clr) | rise;
    end

`ifdef IRQ_RR_EN
    logic [ID_W-1:0] rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (take_ok) begin
            rr_ptr_q <= (irq_id_q == ID_W'(NUM_IRQ - 1)) ? '0 : irq_id_q + ID_W'(1);
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .active_i  (active),
        .rr_ptr_i  (rr_ptr),
        .valid_c_o (sel_valid),
        .sel_c_o   (sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q       <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            taken_cnt_q <= '0;
            state_q     <= ST_IDLE;
            ir_out_q    <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            if (cfg_we && (cfg_addr == CFG_MASK)) begin
                mask_q <= cfg_wdata[NUM_IRQ-1:0];
            end
            case (state_q)
                ST_IDLE: begin
                    if (ir_en && sel_valid) begin
                        irq_id_q <= sel;
                        ir_out_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Acceptance beats withdrawal when both happen together.
                    if (ir_taken) begin
                        ir_out_q    <= 1'b0;
                        taken_cnt_q <= taken_cnt_q + 32'd1;
                        state_q     <= ST_SERVICE;
                    end else if (!ir_en || !active[irq_id_q]) begin
                        ir_out_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (eret) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ir_out_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ir_out = ir_out_q;
    assign irq_id = irq_id_q;
    assign busy   = (state_q == ST_REQ) || (state_q == ST_SERVICE);

    always_comb begin
        cause.busy  = busy;
        cause.state = state_q;
        cause.id    = 29'(irq_id_q);
        case (cfg_addr)
            CFG_MASK:  cfg_rdata = 32'(mask_q);
            CFG_PEND:  cfg_rdata = 32'(pending_q);
            CFG_CAUSE: cfg_rdata = cause;
            default:   cfg_rdata = taken_cnt_q;
        endcase
    end

endmodule
